ifu_fetch: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decoder (`ctrl`) and feeds it one 32-bit instruction at a time.
- Owns the architectural PC, runs a fetch FSM against a variable-latency instruction-memory port, and presents fetched instructions over a valid/ready handshake.
- Accepts branch/jump redirects from execute.
- Kills any fetch that is in flight or buffered when a redirect arrives.

---
 rtl/ifu_fetch_pkg.sv | 17 +
 rtl/ifu_fetch_pc_reg.sv | 38 +++
 rtl/ifu_fetch.sv | 126 ++++++++++++
 tb/tb_ifu_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_OUT  = 2'd2
  } if_state_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// Architectural PC register: reset value, one-word advance, redirect override.
module ifu_fetch_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(RESET_PC_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_i,
  input  logic [CPU_WIDTH-1:0] redirect_pc_i,
  input  logic                 advance_i,
  output logic [CPU_WIDTH-1:0] pc_o
);

  logic [CPU_WIDTH-1:0] pc_d, pc_q;

  // Redirect outranks the sequential advance; the add wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + CPU_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding imem request, single-entry output buffer,
// redirects kill in-flight or buffered fetches.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(RESET_PC_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [CPU_WIDTH-1:0] imem_resp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  output logic                 inst_fault,
  output if_state_e            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // imem_req_addr and the inst/inst_pc/inst_fault bundle stay stable while
  // their valid is high and ready is low; a redirect may still withdraw them.

  if_state_e            state_d, state_q;
  logic                 kill_d, kill_q;
  logic [CPU_WIDTH-1:0] inst_d, inst_q;
  logic [CPU_WIDTH-1:0] inst_pc_d, inst_pc_q;
  logic                 fault_d, fault_q;
  logic                 advance;
  logic [CPU_WIDTH-1:0] pc;

  ifu_fetch_pc_reg #(
    .CPU_WIDTH (CPU_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_o          (pc)
  );

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    fault_d        = fault_q;
    advance        = 1'b0;
    imem_req_valid = 1'b0;
    case (state_q)
      IF_REQ: begin
        if (pc_misaligned(pc[1:0])) begin
          // A misaligned PC is never sent to memory; deliver a fault slot instead.
          if (!redirect_valid) begin
            state_d   = IF_OUT;
            inst_d    = '0;
            inst_pc_d = pc;
            fault_d   = 1'b1;
          end
        end else begin
          imem_req_valid = !rst;
          if (imem_req_ready) begin
            state_d = IF_WAIT;
            kill_d  = redirect_valid;
          end
        end
      end
      IF_WAIT: begin
        if (imem_resp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = IF_REQ;
          end else begin
            state_d   = IF_OUT;
            inst_d    = imem_resp_data;
            inst_pc_d = pc;
            fault_d   = 1'b0;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      IF_OUT: begin
        if (redirect_valid) begin
          state_d = IF_REQ;
        end else if (inst_ready) begin
          state_d = IF_REQ;
          advance = 1'b1;
        end
      end
      default: state_d = IF_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IF_REQ;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_req_addr = pc;
  assign inst_valid    = (state_q == IF_OUT) && !rst;
  assign inst          = inst_valid ? inst_q : '0;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = inst_valid && fault_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: imem responder model, request and instruction scoreboards.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  if_state_e   dbg_state;

  ifu_fetch #(
    .CPU_WIDTH (32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault),
    .dbg_state       (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] exp_q[$];   // {fault, pc, inst}
  logic [31:0] req_q[$];   // expected request addresses, in order

  // memory model knobs and state
  bit          mem_ready_en = 1'b1;
  bit          mem_rand     = 1'b0;
  int          mem_delay    = 0;
  bit          mem_pend     = 1'b0;
  int          mem_cnt      = 0;
  logic [31:0] mem_addr     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0093;
      32'h8000_0008: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endcase
  endfunction

  // Accept requests and score instruction transfers on the falling edge,
  // where every signal is stable for the coming rising edge.
  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", 32'(mem_pend), 32'd0);
      if (req_q.size() == 0) chk("req_expected", 32'(req_q.size()), 32'd1);
      else chk("req_addr", imem_req_addr, req_q.pop_front());
      mem_addr = imem_req_addr;
      mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
      mem_pend = 1'b1;
    end
    if (!inst_valid) chk("inst_idle_zero", inst, 32'd0);
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("inst_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e[63:32]);
        chk("inst", inst, e[31:0]);
        chk("inst_fault", 32'(inst_fault), 32'(e[64]));
      end
    end
  end

  // Response and ready are driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_fn(mem_addr);
        mem_pend        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_req_ready = mem_ready_en && (mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 40);
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    while (!mem_pend && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_pend), 32'd1);
  endtask

  initial begin
    int n;
    int cyc;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);

    // first fetch from the reset vector, zero-wait memory
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0004);
    exp_q.push_back({1'b0, 32'h8000_0000, 32'h0010_0093});
    inst_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    wait_valid("first_valid", n);
    chk("latency", 32'(n + 1), 32'd3);
    tick();
    inst_ready = 1'b0;

    // backpressure: instruction at +4 held for five cycles
    wait_valid("bp_valid", n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_inst", inst, mem_fn(32'h8000_0004));
      chk("bp_pc", inst_pc, 32'h8000_0004);
      chk("bp_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    exp_q.push_back({1'b0, 32'h8000_0004, mem_fn(32'h8000_0004)});
    req_q.push_back(32'h8000_0008);
    mem_delay = 3;
    tick();
    inst_ready = 1'b1;

    // redirect while the request to +8 is outstanding
    wait_pend("wait_accept_08");
    chk("state_wait", 32'(dbg_state), 32'(IF_WAIT));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    inst_ready     = 1'b0;
    tick();
    redirect_valid = 1'b0;
    req_q.push_back(32'h8000_0100);
    mem_delay = 0;
    wait_valid("redir_wait_valid", n);
    chk("redir_wait_pc", inst_pc, 32'h8000_0100);
    chk("redir_wait_inst", inst, mem_fn(32'h8000_0100));

    // redirect together with inst_ready in OUT: slot dropped, target fetched
    tick();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    req_q.push_back(32'h8000_0200);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(negedge clk);
    chk("redir_out_drop", 32'(inst_valid), 32'd0);
    chk("redir_out_addr", imem_req_addr, 32'h8000_0200);
    wait_valid("redir_out_valid", n);
    chk("redir_out_pc", inst_pc, 32'h8000_0200);

    // misaligned redirect target
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    wait_valid("mis_valid", n);
    chk("mis_fault", 32'(inst_fault), 32'd1);
    chk("mis_inst", inst, 32'd0);
    chk("mis_pc", inst_pc, 32'h8000_0102);
    exp_q.push_back({1'b1, 32'h8000_0102, 32'h0000_0000});
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    req_q.push_back(32'h8000_0300);
    mem_delay = 3;
    tick();
    redirect_valid = 1'b0;

    // reset while waiting; the late response must be ignored
    wait_pend("wait_accept_300");
    rst          = 1'b1;
    mem_ready_en = 1'b0;
    tick();
    rst = 1'b0;
    req_q.push_back(32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", 32'(inst_valid), 32'd0);
      chk("rst_mid_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst_mid_addr", imem_req_addr, 32'h8000_0000);
    end
    chk("stale_resp_drained", 32'(mem_pend), 32'd0);

    // random stream: random ready, latency and consumer backpressure
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back({1'b0, 32'h8000_0000 + 32'(4 * i), mem_fn(32'h8000_0000 + 32'(4 * i))});
      req_q.push_back(32'h8000_0004 + 32'(4 * i));
    end
    mem_rand     = 1'b1;
    mem_ready_en = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    inst_ready = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    wait_valid("stream_last_valid", n);
    chk("stream_last_pc", inst_pc, 32'h8000_0050);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
